if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 00).
REQ-002 clk  in  1  pipeline clock; all state SHALL update on the falling edge, matching the pipeline registers.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  hazard unit hold request; while high, IF/ID outputs SHALL be held.
REQ-005 branch_taken  in  1  redirect request (nPC_sel from EX).
REQ-006 branch_imm16  in  16  branch offset in words, signed.
REQ-007 branch_pc4  in  32  PC+4 of the branch instruction.
REQ-008 imem_req  out  1  instruction memory read request, level.
REQ-009 imem_addr  out  32  word-aligned read address.
REQ-010 imem_ack  in  1  imem_rdata valid for the current imem_addr at this edge.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 inst  out  32  IF/ID instruction register.
REQ-013 inst_valid  out  1  inst holds a real instruction; 0 means bubble.
REQ-014 inst_pc4  out  32  PC+4 of inst.

Function
REQ-015 The block SHALL implement states IDLE, REQ and HOLD, plus a 32-bit pc register, a 32-bit hold buffer and a hold-PC buffer.
REQ-016 In IDLE, imem_req SHALL be 0; next edge -> REQ.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until ack or redirect.
REQ-018 REQ, ack=1, stall=0: inst<=imem_rdata, inst_valid<=1, inst_pc4<=pc+4, pc<=pc+4, stay REQ (one instruction per cycle with single-cycle memory).
REQ-019 REQ, ack=1, stall=1: buffer<=imem_rdata, buffered PC+4<=pc+4, pc<=pc+4, IF/ID outputs unchanged, -> HOLD.
REQ-020 REQ, ack=0, stall=0: inst<=0, inst_valid<=0 (bubble), pc unchanged.
REQ-021 REQ, ack=0, stall=1: outputs unchanged.
REQ-022 In HOLD, imem_req SHALL be 0. While stall=1, all state SHALL be held. When stall=0, inst<=buffer, inst_valid<=1, inst_pc4<=buffered PC+4, -> REQ.
REQ-023 The redirect target SHALL be {branch_pc4[31:2],2'b00} + (sign_extend(branch_imm16) << 2), computed modulo 2^32.
REQ-024 On branch_taken=1 at an edge, in any non-IDLE state:
- pc<=target, inst<=0, inst_valid<=0, buffer discarded, -> REQ.
- This SHALL take priority over stall and over a coincident imem_ack, whose data SHALL be dropped.
REQ-025 branch_taken in IDLE SHALL load pc<=target and go to REQ.
REQ-026 The pc increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 imem_ack while imem_req=0 SHALL be ignored.
REQ-028 Fetch latency SHALL be one clock from the ack edge to inst visible; there SHALL be no combinational path from imem_rdata to inst.

Reset
REQ-029 While reset=1:
- state=IDLE, pc=RESET_PC, imem_req=0.
- inst=0, inst_valid=0, inst_pc4=0, buffer=0.
REQ-030 Reset asserted mid-request or in HOLD SHALL abandon the fetch immediately; the first request after release SHALL be to RESET_PC.

Verification
REQ-031 Reset release, ack tied 1, rdata=addr -> imem_addr 0,4,8 on consecutive cycles; inst=0,4,8 with inst_valid=1 one edge later; inst_pc4=4,8,12.
REQ-032 Ack at pc=8 with stall=1 for 3 edges -> inst stays at word 4, imem_req=0 during hold; after stall falls, inst=word 8, then fetch resumes at 12.
REQ-033 branch_taken=1, branch_pc4=0x20, imm16=0xFFFE, coincident ack -> pc=0x18, inst_valid=0, ack data dropped; next fetch at 0x18.
REQ-034 Ack delayed 2 cycles -> imem_addr stable, two bubbles (inst_valid=0), then the valid instruction.
REQ-035 RESET_PC=32'hFFFF_FFFC, ack=1 -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-036 Reset asserted in HOLD with stall=1 -> all outputs 0 asynchronously; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory and fills the
// IF/ID register, parking one early-arriving word while the pipeline is stalled.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm16,
  input  logic [31:0] branch_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic        inst_valid_reg;
  logic [31:0] inst_pc4_reg;
  logic [31:0] buf_reg;
  logic [31:0] buf_pc4_reg;

  logic [31:0] target_next;
  logic [31:0] pc_plus4_next;

  // Masking the low bits of branch_pc4 word-aligns the base before adding the offset.
  assign target_next   = (branch_pc4 & 32'hFFFF_FFFC)
                       + {{14{branch_imm16[15]}}, branch_imm16, 2'b00};
  assign pc_plus4_next = pc_reg + 32'd4;

  assign imem_req   = (state_reg == REQ);
  assign imem_addr  = pc_reg;
  assign inst       = inst_reg;
  assign inst_valid = inst_valid_reg;
  assign inst_pc4   = inst_pc4_reg;

  // The pipeline registers advance on the falling edge, so this stage does too.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      inst_reg       <= 32'd0;
      inst_valid_reg <= 1'b0;
      inst_pc4_reg   <= 32'd0;
      buf_reg        <= 32'd0;
      buf_pc4_reg    <= 32'd0;
    end else if (state_reg == IDLE) begin
      if (branch_taken) begin
        pc_reg <= target_next;
      end
      state_reg <= REQ;
    end else if (branch_taken) begin
      // Redirect wins over stall and drops any word returned on this edge.
      pc_reg         <= target_next;
      inst_reg       <= 32'd0;
      inst_valid_reg <= 1'b0;
      buf_reg        <= 32'd0;
      buf_pc4_reg    <= 32'd0;
      state_reg      <= REQ;
    end else begin
      case (state_reg)
        REQ: begin
          if (imem_ack && !stall) begin
            inst_reg       <= imem_rdata;
            inst_valid_reg <= 1'b1;
            inst_pc4_reg   <= pc_plus4_next;
            pc_reg         <= pc_plus4_next;
          end else if (imem_ack && stall) begin
            buf_reg     <= imem_rdata;
            buf_pc4_reg <= pc_plus4_next;
            pc_reg      <= pc_plus4_next;
            state_reg   <= HOLD;
          end else if (!stall) begin
            inst_reg       <= 32'd0;
            inst_valid_reg <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_reg       <= buf_reg;
            inst_valid_reg <= 1'b1;
            inst_pc4_reg   <= buf_pc4_reg;
            state_reg      <= REQ;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
